mem_controller: RTL
===================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 17, byte-address width; LEN, default 32, word width; ENTRY_INDEX_SIZE, default 3, width of write-length field.
REQ-002 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 i_vis_signal  input  2  instruction-side request: NOP=0, READ=1; other codes treated as NOP.
REQ-006 i_vis_addr  input  ADDR_WIDTH  instruction byte address, word-aligned.
REQ-007 d_vis_signal  input  2  data-side request: NOP=0, READ=1, WRITE=2, READ_BURST=3.
REQ-008 d_vis_addr  input  ADDR_WIDTH  data start byte address, sampled at task acceptance only.
REQ-009 d_writen_data  input  LEN  write word for the current beat.
REQ-010 d_write_length  input  ENTRY_INDEX_SIZE  number of write beats; 0 means 2^ENTRY_INDEX_SIZE.
REQ-011 mem_data  output  LEN  read word returned to the requester.
REQ-012 mem_status  output  2  RESTING=0, INST_WORKING=1, DATA_WORKING=2, FINISHED=3.
REQ-013 i_data_valid / d_data_valid  output  1 each  one-cycle pulse marking mem_data valid for that side.

Function
REQ-014 SHALL contain a word-organised RAM of 2^(ADDR_WIDTH-2) words, indexed by addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
REQ-015 SHALL implement FSM states IDLE, INST_READ, DATA_READ, DATA_BURST, DATA_WRITE, DONE.
REQ-016 IDLE: if d_vis_signal != NOP, accept data task; else if i_vis_signal == READ, accept instruction task; else remain IDLE with mem_status=RESTING.
REQ-017 Data side SHALL win a simultaneous request; the instruction request is not latched and must be held by its requester.
REQ-018 On acceptance, SHALL latch the address into a beat pointer, clear the beat counter and latch d_write_length; mem_status becomes INST_WORKING or DATA_WORKING on the next cycle.
REQ-019 INST_READ/DATA_READ: one cycle after acceptance, mem_data=RAM[ptr] and the matching *_data_valid=1; next state DONE.
REQ-020 DATA_BURST: each cycle, mem_data=RAM[ptr], d_data_valid=1 and ptr+=4 while d_vis_signal==READ_BURST; d_vis_signal==NOP ends the burst and enters DONE without a further beat.
REQ-021 DATA_WRITE: each cycle with d_vis_signal==WRITE, write d_writen_data to RAM[ptr], ptr+=4, beat counter+1; after the beat equal to the latched length, enter DONE. A NOP beat stalls without writing.
REQ-022 The first write beat SHALL be the cycle after acceptance; the beat in the acceptance cycle is not written.
REQ-023 DONE: mem_status=FINISHED for exactly one cycle, then IDLE/RESTING; no request is accepted in DONE.
REQ-024 ptr SHALL wrap modulo 2^ADDR_WIDTH past the top address without error.
REQ-025 mem_data SHALL hold its last value when no valid pulse is asserted.
REQ-026 A change of d_vis_signal code mid-task other than NOP SHALL be ignored; the task type is fixed at acceptance.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, mem_status=RESTING, mem_data=0, both valid pulses=0, ptr and counters=0; RAM contents are not cleared.
REQ-028 Reset asserted mid-task SHALL abort it; writes already performed remain and no FINISHED is issued.

Verification
REQ-029 Preload RAM[0x10]=0xA5A5_0001; i READ at 0x40 -> 1 cycle later mem_data=0xA5A5_0001, i_data_valid=1, then FINISHED for 1 cycle, then RESTING.
REQ-030 Simultaneous i READ 0x0 and d READ 0x8 -> data served first (d_data_valid); instruction served after DONE while i request held.
REQ-031 d WRITE at 0x100, length 3, data 1,2,3 -> RAM words 0x40..0x42 = 1,2,3; FINISHED after third beat; 0x43 unchanged.
REQ-032 d READ_BURST at 0x100 held 8 cycles then NOP -> 8 consecutive d_data_valid pulses, words 0x40..0x47 in order.
REQ-033 Burst starting at top word 0x1FFFC for 2 beats -> second beat returns word 0 (wrap).
REQ-034 rst asserted after 2 of 4 write beats -> RESTING next cycle, exactly 2 words written, no FINISHED.

Source files
------------

// File: rtl/mem_controller.sv
// Word-organised RAM controller with one instruction read port and a data port
// that serves single reads, bursts, and counted multi-beat writes.
module mem_controller #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  i_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       i_vis_addr,
  input  logic [1:0]                  d_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       d_vis_addr,
  input  logic [LEN-1:0]              d_writen_data,
  input  logic [ENTRY_INDEX_SIZE-1:0] d_write_length,
  output logic [LEN-1:0]              mem_data,
  output logic [1:0]                  mem_status,
  output logic                        i_data_valid,
  output logic                        d_data_valid
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CW    = ENTRY_INDEX_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE, INST_READ, DATA_READ, DATA_BURST, DATA_WRITE, DONE
  } state_t;

  state_t                        state, state_nx;
  logic [ADDR_WIDTH-1:0]         ptr;
  logic [CW-1:0]                 cnt;
  logic [ENTRY_INDEX_SIZE-1:0]   len_q;
  logic [CW-1:0]                 len_eff;
  logic [LEN-1:0]                data_q;
  logic [LEN-1:0]                ram [DEPTH];
  logic [ADDR_WIDTH-3:0]         idx;
  logic                          d_req;
  logic                          i_req;
  logic                          beat;
  logic                          wr_en;
  logic                          bst_en;

  assign idx   = ptr[ADDR_WIDTH-1:2];
  assign d_req = d_vis_signal != 2'd0;
  assign i_req = i_vis_signal == 2'd1;
  // Inside a task any non-NOP code counts as a beat of the latched task type.
  assign beat  = d_vis_signal != 2'd0;

  // A zero length field encodes the full 2^ENTRY_INDEX_SIZE beats.
  assign len_eff = (len_q == '0) ? {1'b1, {ENTRY_INDEX_SIZE{1'b0}}}
                                 : {1'b0, len_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (d_req) begin
          case (d_vis_signal)
            2'd1:    state_nx = DATA_READ;
            2'd2:    state_nx = DATA_WRITE;
            default: state_nx = DATA_BURST;
          endcase
        end else if (i_req) begin
          state_nx = INST_READ;
        end
      end
      INST_READ:  state_nx = DONE;
      DATA_READ:  state_nx = DONE;
      DATA_BURST: if (!beat) state_nx = DONE;
      DATA_WRITE: if (beat && (cnt + CW'(1)) == len_eff) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    i_data_valid = !rst && (state == INST_READ);
    bst_en       = !rst && (state == DATA_BURST) && beat;
    d_data_valid = (!rst && (state == DATA_READ)) || bst_en;
    wr_en        = !rst && (state == DATA_WRITE) && beat;
    mem_data     = (i_data_valid || d_data_valid) ? ram[idx] : data_q;
    case (state)
      IDLE:      mem_status = 2'd0;
      INST_READ: mem_status = 2'd1;
      DONE:      mem_status = 2'd3;
      default:   mem_status = 2'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      data_q <= '0;
    end else begin
      if (state == IDLE) begin
        if (d_req) begin
          ptr   <= d_vis_addr;
          cnt   <= '0;
          len_q <= d_write_length;
        end else if (i_req) begin
          ptr <= i_vis_addr;
          cnt <= '0;
        end
      end
      if (i_data_valid || d_data_valid) data_q <= ram[idx];
      if (bst_en || wr_en) ptr <= ptr + ADDR_WIDTH'(4);
      if (wr_en) cnt <= cnt + CW'(1);
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram[idx] <= d_writen_data;
  end

endmodule
